dat_access_arbiter: RTL

Shares the single-port Device Address Table memory between several hardware readers (command executor, IBI handler, ENTDAA engine) and the software CSR window. Each access is serialised through a small FSM. Hardware requesters get full 64-bit entries. Software gets 32-bit word reads and masked 32-bit word writes. A watchdog keeps a stalled memory from hanging the bus. The block sits between the controller logic, the DAT CSR hwif and the exported DAT memory port.

---
 rtl/dat_access_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dat_access_arbiter.sv
`default_nettype none
// ============================================================================
// dat_access_arbiter - serialises HW readers and the SW CSR window onto the
// single-port DAT memory (round-robin, read watchdog).       Rev 1.0
// ============================================================================
module dat_access_arbiter #(
   parameter int unsigned NumReq     = 3,
   parameter int unsigned DatAw      = 7,
   parameter int unsigned RspTimeout = 15
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NumReq-1:0]       hw_req_i,
   input  logic [NumReq*DatAw-1:0] hw_index_i,
   output logic [NumReq-1:0]       hw_gnt_o,
   output logic [NumReq-1:0]       hw_rvalid_o,
   output logic [63:0]             hw_rdata_o,
   input  logic                    sw_req_i,
   input  logic                    sw_we_i,
   input  logic [DatAw-1:0]        sw_index_i,
   input  logic                    sw_word_i,
   input  logic [31:0]             sw_wdata_i,
   output logic                    sw_rd_ack_o,
   output logic                    sw_wr_ack_o,
   output logic [31:0]             sw_rdata_o,
   output logic                    mem_req_o,
   output logic                    mem_write_o,
   output logic [DatAw-1:0]        mem_addr_o,
   output logic [63:0]             mem_wdata_o,
   output logic [63:0]             mem_wmask_o,
   input  logic                    mem_rvalid_i,
   input  logic [63:0]             mem_rdata_i,
   output logic                    timeout_o
);

   localparam int unsigned       SLOT_W   = $clog2(NumReq + 1);
   localparam logic [SLOT_W-1:0] SW_SLOT  = SLOT_W'(NumReq);
   localparam logic [7:0]        CNT_LAST = 8'(RspTimeout - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d, rr_q, rr_d;
   logic [DatAw-1:0]  addr_q, addr_d;
   logic              we_q, we_d, word_q, word_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [63:0]       rdata_q, rdata_d;

   logic [NumReq:0]   pending;
   logic [DatAw-1:0]  hw_idx [NumReq];
   logic [DatAw-1:0]  win_addr;
   logic [SLOT_W-1:0] cand, win;
   logic              found;
   logic              is_sw;
   logic [31:0]       scan;

   assign pending = {sw_req_i, hw_req_i};
   assign is_sw   = (slot_q == SW_SLOT);

   generate
      for (genvar k = 0; k < NumReq; k++) begin : g_hw_idx
         assign hw_idx[k] = hw_index_i[k*DatAw +: DatAw];
      end
   endgenerate

   // Round-robin search over all slots, starting at rr_q and wrapping at NumReq.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      cand     = '0;
      scan     = '0;
      win_addr = sw_index_i;
      for (int unsigned off = 0; off <= NumReq; off++) begin
         scan = 32'(rr_q) + 32'(off);
         if (scan > NumReq) scan = scan - (NumReq + 1);
         cand = SLOT_W'(scan);
         if (!found && pending[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      for (int k = 0; k < NumReq; k++) begin
         if (win == SLOT_W'(k)) win_addr = hw_idx[k];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         slot_q  <= '0;
         rr_q    <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         word_q  <= 1'b0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         rr_q    <= rr_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      rr_d        = rr_q;
      addr_d      = addr_q;
      we_d        = we_q;
      word_d      = word_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      hw_gnt_o    = '0;
      hw_rvalid_o = '0;
      hw_rdata_o  = '0;
      sw_rd_ack_o = 1'b0;
      sw_wr_ack_o = 1'b0;
      sw_rdata_o  = '0;
      mem_req_o   = 1'b0;
      mem_write_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wmask_o = '0;
      timeout_o   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d = ST_ISSUE;
               slot_d  = win;
               rr_d    = (win == SW_SLOT) ? '0 : win + 1'b1;
               addr_d  = win_addr;
               // SW fields are latched so the issue cycle does not depend on CSR inputs.
               we_d    = (win == SW_SLOT) && sw_we_i;
               word_d  = (win == SW_SLOT) && sw_word_i;
               wdata_d = (win == SW_SLOT) ? sw_wdata_i : 32'h0;
            end
         end
         ST_ISSUE: begin
            mem_req_o  = 1'b1;
            mem_addr_o = addr_q;
            cnt_d      = '0;
            for (int k = 0; k < NumReq; k++) begin
               hw_gnt_o[k] = (slot_q == SLOT_W'(k));
            end
            if (is_sw && we_q) begin
               mem_write_o = 1'b1;
               mem_wmask_o = word_q ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF;
               mem_wdata_o = word_q ? {wdata_q, 32'h0} : {32'h0, wdata_q};
               state_d     = ST_ACK;
            end else begin
               mem_wmask_o = '1;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               rdata_d = mem_rdata_i;
               cnt_d   = '0;
               state_d = ST_ACK;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d   = '0;
               cnt_d     = '0;
               timeout_o = 1'b1;
               state_d   = ST_ACK;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            if (is_sw) begin
               sw_wr_ack_o = we_q;
               sw_rd_ack_o = !we_q;
               sw_rdata_o  = we_q ? 32'h0 : (word_q ? rdata_q[63:32] : rdata_q[31:0]);
            end else begin
               hw_rdata_o = rdata_q;
               for (int k = 0; k < NumReq; k++) begin
                  hw_rvalid_o[k] = (slot_q == SLOT_W'(k));
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire
